// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART byte transmitter
// Ports: clk/rst (sync, active-high); req_valid/req_data/req_last in, req_ready out per requester;
//        grant one-hot owner; tx_start/tx_data drive the transmitter, tx_busy is its status;
//        arb_busy high outside IDLE; timeout_err sticky start-timeout flag.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int START_TIMEOUT = 15,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 arb_busy,
  output logic                 timeout_err
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_BUSY = 3'd2, WAIT_DONE = 3'd3, GAP = 3'd4;
  logic [2:0] state;
  logic [PW-1:0] ptr, gIdx, pickIdx;
  logic [PW:0] scanIdx;
  logic lastFlag;
  logic [7:0] toCnt;
  logic [15:0] gapCnt;
  // Descending scan so the requester closest to the pointer (with wrap) wins.
  always_comb begin
    pickIdx = '0;
    scanIdx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scanIdx = {1'b0, ptr} + (PW+1)'(i);
      scanIdx = (scanIdx >= (PW+1)'(NUM_REQ)) ? scanIdx - (PW+1)'(NUM_REQ) : scanIdx;
      pickIdx = req_valid[scanIdx[PW-1:0]] ? scanIdx[PW-1:0] : pickIdx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      gIdx <= '0;
      ptr <= '0;
      req_ready <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      lastFlag <= 1'b0;
      toCnt <= '0;
      gapCnt <= '0;
      timeout_err <= 1'b0;
      arb_busy <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant <= NUM_REQ'(1) << pickIdx;
          gIdx <= pickIdx;
          arb_busy <= 1'b1;
          state <= LOAD;
        end
        // Grant stays locked here until the owner presents its next byte.
        LOAD: if (req_valid[gIdx]) begin
          tx_data <= req_data[{gIdx, 3'b000} +: 8];
          lastFlag <= req_last[gIdx];
          req_ready[gIdx] <= 1'b1;
          tx_start <= 1'b1;
          toCnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
        else begin
          toCnt <= toCnt + 8'd1;
          // A transmitter that never answers is treated as having sent the byte.
          if (toCnt == 8'(START_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            gapCnt <= '0;
            state <= lastFlag ? GAP : LOAD;
          end
        end
        WAIT_DONE: if (!tx_busy) begin
          gapCnt <= '0;
          state <= lastFlag ? GAP : LOAD;
        end
        GAP: if (32'(gapCnt) + 1 >= GAP_CYCLES) begin
          grant <= '0;
          arb_busy <= 1'b0;
          ptr <= (gIdx == PW'(NUM_REQ - 1)) ? '0 : gIdx + 1'b1;
          state <= IDLE;
        end else gapCnt <= gapCnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_last = '0;
  logic [3:0] req_ready, grant;
  logic tx_start, arb_busy, timeout_err;
  logic [7:0] tx_data;
  logic tx_busy;
  logic autoTx = 1'b0;
  logic busyManual = 1'b0;
  logic busyAuto = 1'b0;
  int busyLen = 3;
  int busyLeft = 0;
  int nCmp = 0;
  int nErr = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(15), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = autoTx ? busyAuto : busyManual;

  always @(posedge clk) begin
    if (tx_start) begin
      busyLeft <= busyLen;
      busyAuto <= 1'b1;
    end else if (busyLeft > 1) busyLeft <= busyLeft - 1;
    else begin
      busyLeft <= 0;
      busyAuto <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (grant !== 4'b0000 && n < 200) begin tick(); n++; end
    nCmp++;
    if (grant !== 4'b0000 || arb_busy !== 1'b0) begin
      nErr++;
      $display("FAIL %s_idle grant=%b arb_busy=%b want grant=0000 arb_busy=0", name, grant, arb_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    nCmp++;
    if ({grant, req_ready, tx_start, arb_busy, timeout_err, tx_data} !== 19'd0) begin
      nErr++;
      $display("FAIL reset_outputs grant=%b ready=%b start=%b busy=%b terr=%b data=%h want all 0",
               grant, req_ready, tx_start, arb_busy, timeout_err, tx_data);
    end
  endtask

  task automatic test_single_byte();
    autoTx = 1'b0;
    req_data[7:0] = 8'h41;
    req_last[0] = 1'b1;
    req_valid = 4'b0001;
    tick();
    nCmp++;
    if (grant !== 4'b0001 || tx_start !== 1'b0 || arb_busy !== 1'b1) begin
      nErr++;
      $display("FAIL single_grant grant=%b start=%b arb_busy=%b want 0001/0/1", grant, tx_start, arb_busy);
    end
    tick();
    nCmp++;
    if (tx_start !== 1'b1 || req_ready !== 4'b0001 || tx_data !== 8'h41) begin
      nErr++;
      $display("FAIL single_start start=%b ready=%b data=%h want 1/0001/41", tx_start, req_ready, tx_data);
    end
    req_valid = 4'b0000;
    busyManual = 1'b1;
    tick();
    nCmp++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin
      nErr++;
      $display("FAIL single_pulse start=%b ready=%b want 0/0000", tx_start, req_ready);
    end
    repeat (19) tick();
    busyManual = 1'b0;
    tick();
    nCmp++;
    if (grant !== 4'b0001) begin
      nErr++;
      $display("FAIL single_gap_hold grant=%b want 0001", grant);
    end
    tick();
    nCmp++;
    if (grant !== 4'b0000 || arb_busy !== 1'b0) begin
      nErr++;
      $display("FAIL single_release grant=%b arb_busy=%b want 0000/0", grant, arb_busy);
    end
  endtask

  task automatic test_packet();
    logic [7:0] exp [3] = '{8'h10, 8'h20, 8'h30};
    int starts = 0;
    int bad = 0;
    int n = 0;
    autoTx = 1'b1;
    busyLen = 3;
    req_data[23:16] = 8'h10;
    req_last[2] = 1'b0;
    req_valid = 4'b0100;
    tick();
    nCmp++;
    if (grant !== 4'b0100) begin
      nErr++;
      $display("FAIL pkt_grant grant=%b want 0100", grant);
    end
    req_data[15:8] = 8'h51;
    req_last[1] = 1'b1;
    req_valid[1] = 1'b1;
    while (grant !== 4'b0010 && n < 300) begin
      tick();
      n++;
      if (req_ready[1]) bad++;
      if (tx_start) begin
        nCmp++;
        if (starts >= 3 || grant !== 4'b0100 || tx_data !== exp[starts]) begin
          nErr++;
          $display("FAIL pkt_byte%0d grant=%b data=%h want 0100/%h", starts, grant, tx_data,
                   starts < 3 ? exp[starts] : 8'h00);
        end
        starts++;
      end
      if (req_ready[2]) begin
        req_data[23:16] = starts == 1 ? 8'h20 : 8'h30;
        req_last[2] = starts == 2;
        if (starts >= 3) req_valid[2] = 1'b0;
      end
    end
    nCmp++;
    if (starts != 3 || bad != 0 || grant !== 4'b0010) begin
      nErr++;
      $display("FAIL pkt_lock starts=%0d foreign_ready=%0d grant=%b want 3/0/0010", starts, bad, grant);
    end
    n = 0;
    while (!tx_start && n < 50) begin tick(); n++; end
    nCmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'h51 || req_ready !== 4'b0010) begin
      nErr++;
      $display("FAIL pkt_next start=%b data=%h ready=%b want 1/51/0010", tx_start, tx_data, req_ready);
    end
    req_valid[1] = 1'b0;
    wait_idle("pkt");
  endtask

  task automatic test_round_robin();
    int starts = 0;
    int n = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
    req_last = 4'b1111;
    req_valid = 4'b1111;
    while (starts < 6 && n < 400) begin
      tick();
      n++;
      if (tx_start) begin
        nCmp++;
        if (grant !== (4'b0001 << (starts % 4)) || tx_data !== 8'hA0 + 8'(starts % 4)) begin
          nErr++;
          $display("FAIL rr_turn%0d grant=%b data=%h want %b/%h", starts, grant, tx_data,
                   4'b0001 << (starts % 4), 8'hA0 + 8'(starts % 4));
        end
        starts++;
        if (starts == 6) req_valid = 4'b0000;
      end
    end
    nCmp++;
    if (starts != 6) begin
      nErr++;
      $display("FAIL rr_count starts=%0d want 6", starts);
    end
    wait_idle("rr");
  endtask

  task automatic test_stall();
    int n = 0;
    int stallStarts = 0;
    int stallBad = 0;
    req_data[31:24] = 8'hC1;
    req_last = 4'b0000;
    req_valid = 4'b1000;
    while (!req_ready[3] && n < 50) begin tick(); n++; end
    nCmp++;
    if (req_ready[3] !== 1'b1 || tx_data !== 8'hC1 || grant !== 4'b1000) begin
      nErr++;
      $display("FAIL stall_byte1 ready=%b data=%h grant=%b want 1/C1/1000", req_ready[3], tx_data, grant);
    end
    req_valid = 4'b0000;
    repeat (50) begin
      tick();
      if (tx_start) stallStarts++;
      if (grant !== 4'b1000) stallBad++;
    end
    nCmp++;
    if (stallStarts != 0 || stallBad != 0) begin
      nErr++;
      $display("FAIL stall_hold starts=%0d grant_lost=%0d want 0/0", stallStarts, stallBad);
    end
    req_data[31:24] = 8'hC2;
    req_last[3] = 1'b1;
    req_valid = 4'b1000;
    n = 0;
    while (!tx_start && n < 20) begin tick(); n++; end
    nCmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'hC2 || grant !== 4'b1000) begin
      nErr++;
      $display("FAIL stall_byte2 start=%b data=%h grant=%b want 1/C2/1000", tx_start, tx_data, grant);
    end
    req_valid = 4'b0000;
    wait_idle("stall");
  endtask

  task automatic test_timeout();
    int n = 0;
    autoTx = 1'b0;
    busyManual = 1'b0;
    req_data[7:0] = 8'h71;
    req_last = 4'b0000;
    req_valid = 4'b0001;
    while (!tx_start && n < 20) begin tick(); n++; end
    nCmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'h71 || timeout_err !== 1'b0) begin
      nErr++;
      $display("FAIL to_start start=%b data=%h terr=%b want 1/71/0", tx_start, tx_data, timeout_err);
    end
    req_data[7:0] = 8'h72;
    req_last[0] = 1'b1;
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    nCmp++;
    if (timeout_err !== 1'b1 || n != 15) begin
      nErr++;
      $display("FAIL to_latency terr=%b cycles=%0d want 1/15", timeout_err, n);
    end
    n = 0;
    while (!tx_start && n < 20) begin tick(); n++; end
    nCmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'h72 || n != 1) begin
      nErr++;
      $display("FAIL to_next start=%b data=%h cycles=%0d want 1/72/1", tx_start, tx_data, n);
    end
    req_valid = 4'b0000;
    wait_idle("to");
    nCmp++;
    if (timeout_err !== 1'b1) begin
      nErr++;
      $display("FAIL to_sticky terr=%b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int starts = 0;
    logic [1:0] served = 2'b00;
    autoTx = 1'b1;
    busyLen = 10;
    req_data[15:8] = 8'h81;
    req_last = 4'b0000;
    req_valid = 4'b0010;
    while (starts < 2 && n < 100) begin
      tick();
      n++;
      if (tx_start) begin
        starts++;
        req_data[15:8] = starts == 1 ? 8'h82 : 8'h83;
        req_last[1] = starts == 2;
      end
    end
    tick(); tick();
    nCmp++;
    if (starts != 2 || tx_data !== 8'h82 || arb_busy !== 1'b1 || tx_busy !== 1'b1) begin
      nErr++;
      $display("FAIL rstmid_setup starts=%0d data=%h arb_busy=%b tx_busy=%b want 2/82/1/1",
               starts, tx_data, arb_busy, tx_busy);
    end
    rst = 1'b1;
    tick();
    nCmp++;
    if ({grant, req_ready, tx_start, arb_busy, timeout_err} !== 11'd0) begin
      nErr++;
      $display("FAIL rstmid_clear grant=%b ready=%b start=%b arb_busy=%b terr=%b want all 0",
               grant, req_ready, tx_start, arb_busy, timeout_err);
    end
    rst = 1'b0;
    req_valid = 4'b0000;
    n = 0;
    while (tx_busy && n < 30) begin tick(); n++; end
    req_data[15:0] = 16'hE1E0;
    req_last = 4'b0011;
    req_valid = 4'b0011;
    tick();
    nCmp++;
    if (grant !== 4'b0001) begin
      nErr++;
      $display("FAIL rstmid_ptr grant=%b want 0001", grant);
    end
    starts = 0;
    n = 0;
    while (served != 2'b11 && n < 200) begin
      tick();
      n++;
      if (tx_start) begin
        nCmp++;
        if (tx_data !== (starts == 0 ? 8'hE0 : 8'hE1)) begin
          nErr++;
          $display("FAIL rstmid_fresh%0d data=%h want %h", starts, tx_data, starts == 0 ? 8'hE0 : 8'hE1);
        end
        starts++;
      end
      for (int i = 0; i < 2; i++) if (req_ready[i]) begin served[i] = 1'b1; req_valid[i] = 1'b0; end
    end
    nCmp++;
    if (served != 2'b11 || starts != 2) begin
      nErr++;
      $display("FAIL rstmid_served served=%b starts=%0d want 11/2", served, starts);
    end
    wait_idle("rstmid");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_packet();
    test_round_robin();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
